// File: rtl/amba_slv_mem.sv
// ============================================================================
// Module : amba_slv_mem
// AHB-Lite word-organised memory slave with configurable wait states.
// Define AMBA_SLV_ERR_EN to return ERROR for out-of-range, oversize or misaligned accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package amba_slv_pkg;
   localparam int AWIDTH       = 32;
   localparam int S_ADDR_WIDTH = 16;
endpackage

module amba_slv_mem
   import amba_slv_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hsel,
   input  logic [AWIDTH-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [DWIDTH-1:0] hwdata,
   input  logic              hready,
   output logic [DWIDTH-1:0] hrdata,
   output logic              hreadyout,
   output logic              hresp
);

   localparam int c_ow = AWIDTH - S_ADDR_WIDTH;
   localparam int c_iw = $clog2(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DATA = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic [c_iw-1:0]     r_idx;
   logic [1:0]          r_lane;
   logic [1:0]          r_size;
   logic                r_write;
   logic [DWIDTH-1:0]   r_mem [DEPTH];
   logic [DWIDTH-1:0]   r_hrdata;
   logic                r_hreadyout;

   logic [c_ow-1:0]     w_offset;
   logic [c_iw-1:0]     w_idx;
   logic [1:0]          w_size;
   logic                w_acc;
   logic                w_err;
   logic                w_ld;
   logic                w_commit;
   logic [3:0]          w_lmask;
   logic [DWIDTH-1:0]   w_bmask;
   logic [DWIDTH-1:0]   w_merged;
   logic [c_iw-1:0]     w_rd_idx;
   logic [DWIDTH-1:0]   w_rd_data;

   function automatic logic [3:0] f_lanes(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'd0:    f_lanes = 4'b0001 << lane;
         2'd1:    f_lanes = lane[1] ? 4'b1100 : 4'b0011;
         default: f_lanes = 4'b1111;
      endcase
   endfunction

   assign w_offset = haddr[c_ow-1:0];
   assign w_idx    = w_offset[c_iw+1:2];
   assign w_size   = (hsize > 3'd2) ? 2'd2 : hsize[1:0];
   assign w_acc    = hsel & hready & htrans[1] &
                     ((r_state == ST_IDLE) | (r_state == ST_DATA) | (r_state == ST_ERR2));

`ifdef AMBA_SLV_ERR_EN
   logic w_unused_bits;
   assign w_unused_bits = ^{haddr[AWIDTH-1:c_ow], htrans[0]};
   assign w_err = (32'(w_offset) >= 32'(DEPTH*4)) || (hsize > 3'd2) ||
                  ((hsize == 3'd1) && haddr[0]) ||
                  ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
`else
   logic w_unused_bits;
   assign w_unused_bits = ^{haddr[AWIDTH-1:c_ow], htrans[0], w_offset[c_ow-1:c_iw+2]};
   assign w_err = 1'b0;
`endif

   // Write merge: only the lanes named by the captured size/address change.
   assign w_lmask = f_lanes(r_size, r_lane);
   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_bmask[8*i +: 8] = {8{w_lmask[i]}};
   end
   assign w_commit = (r_state == ST_DATA) & r_write;
   assign w_merged = (r_mem[r_idx] & ~w_bmask) | (hwdata & w_bmask);

   // Zero-wait reads look up the live address; delayed reads use the captured one.
   assign w_rd_idx  = (r_state == ST_WAIT) ? r_idx : w_idx;
   assign w_rd_data = (w_commit && (w_rd_idx == r_idx)) ? w_merged : r_mem[w_rd_idx];

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_ld      = 1'b0;
      case (r_state)
         ST_WAIT: begin
            if (r_cnt == 4'd1) begin
               w_next = ST_DATA;
               w_ld   = ~r_write;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_ERR1: w_next = ST_ERR2;
         default: begin
            if (w_acc) begin
               if (w_err) begin
                  w_next = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  w_next    = ST_WAIT;
                  w_cnt_nxt = 4'(WAIT_STATES);
               end else begin
                  w_next = ST_DATA;
                  w_ld   = ~hwrite;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_lane      <= 2'd0;
         r_size      <= 2'd0;
         r_write     <= 1'b0;
         r_hrdata    <= '0;
         r_hreadyout <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_nxt;
         r_hreadyout <= (w_next != ST_WAIT) && (w_next != ST_ERR1);
         if (w_acc) begin
            r_idx   <= w_idx;
            r_lane  <= w_offset[1:0];
            r_size  <= w_size;
            r_write <= hwrite;
         end
         if (w_ld) begin
            r_hrdata <= w_rd_data;
         end
      end
   end

   // Storage has no reset; only the control path is cleared.
   always_ff @(posedge hclk) begin
      if (w_commit) begin
         r_mem[r_idx] <= w_merged;
      end
   end

`ifdef AMBA_SLV_ERR_EN
   logic r_hresp;
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_hresp <= 1'b0;
      end else begin
         r_hresp <= (w_next == ST_ERR1) || (w_next == ST_ERR2);
      end
   end
   assign hresp = r_hresp;
`else
   assign hresp = 1'b0;
`endif

   assign hrdata    = r_hrdata;
   assign hreadyout = r_hreadyout;

endmodule

`default_nettype wire
